onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the team's 4-to-2 one-hot encoder.
- Collects up to four request lines and issues at most one registered one-hot grant.
- grant feeds the encoder input vector; grant_valid feeds the encoder enable, so the encoder never sees zero-hot or multi-hot input while enabled.
- Holds a grant until the consumer releases it, the requester drops, or a hold limit expires with contention.

Parameters:
- NREQ, 4, number of requesters; power of two, at least 2; 4 when driving the 4x2 encoder.
- MAX_HOLD, 8, maximum grant cycles before forced rotation when another requester is pending; at least 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  NREQ  request lines; bit k means requester k wants service; level-sensitive.
- done  input  1  consumer release pulse for the current grant.
- grant  output  NREQ  registered grant; always one-hot or all-zero.
- grant_valid  output  1  registered; equals OR of grant; drives encoder enable.

Behaviour:
- Reset (rst_n low, asynchronous):
  - grant=0, grant_valid=0, ptr=0, hold_cnt=0, state=IDLE.
  - Applies mid-grant too: outputs drop immediately, with no GAP cycle.
- States:
  - IDLE: no grant.
  - GRANT: grant held.
  - GAP: one dead cycle.
- IDLE:
  - If req != 0 at edge k, the winner is the first set bit searching ptr, ptr+1, … modulo NREQ.
  - After edge k: grant = one-hot(winner), grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency is 1 cycle from a sampled request to grant.
  - If req == 0, stay in IDLE with outputs 0.
- GRANT, evaluated each edge with g = granted index:
  - Release if any of:
    - done=1;
    - req[g]=0;
    - hold_cnt == MAX_HOLD-1 and (req with bit g cleared) != 0.
  - On release: grant=0, grant_valid=0, ptr=(g+1) mod NREQ, hold_cnt=0, state=GAP.
  - Otherwise: grant unchanged; hold_cnt increments, saturating at MAX_HOLD-1.
  - An uncontended grant is therefore held indefinitely.
  - done and req[g] drop on the same edge count as a single release.
  - Changes on other req bits never alter the current grant.
- GAP:
  - Outputs 0 for exactly one cycle, then IDLE unconditionally.
  - Minimum spacing between consecutive grants is 2 zero cycles: the GAP cycle plus the IDLE arbitration cycle.
- done is ignored in IDLE and GAP.
- ptr only advances on release, never on a grant.
- Width rules:
  - ptr and g are clog2(NREQ) bits; ptr wraps naturally from NREQ-1 to 0.
  - hold_cnt is clog2(MAX_HOLD) bits.
- Invariant checked every cycle: grant_valid == |grant, and $onehot0(grant).

Decomposition:
- Package arb_pkg:
  - state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2);
  - default NREQ/MAX_HOLD constants;
  - clog2 helper function.
- Sub-module rr_pick (purely combinational):
  - Inputs: req, ptr.
  - Outputs: any, idx (winner index), onehot.
  - Implemented as rotate-by-ptr, fixed-priority find-first, rotate back.
  - Instantiated once in onehot_rr_arbiter; reusable by later arbiters.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, then release -> grant=0000 and valid=0 during reset; 1 cycle after release grant=0001 (ptr=0).
- Round-robin: req=4'b1111 constant, done pulsed 1 cycle after each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with 2 zero cycles between grants.
- Pointer skip: after release of index 1 (ptr=2), req=4'b0011 -> grant=0001 (wrap search 2,3,0).
- Hold limit: req=4'b0101, no done -> grant=0001 for exactly 8 cycles, then GAP, then grant=0100; with req=4'b0001 alone -> grant=0001 held 20+ cycles.
- Simultaneous release: done=1 and req[g] drops on the same edge -> one GAP cycle, ptr advances by one only.
- Mid-grant reset: assert rst_n=0 asynchronously while grant=0100 -> grant=0000 without waiting for a clock edge; after release, arbitration restarts from ptr=0.
- End-to-end: drive the encoder from grant/grant_valid; y must equal the granted index whenever valid=1, and be never X while enabled.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin arbiter family.
// Latency: none (package only).
// Backpressure: none (package only).
package arb_pkg;

    // Arbiter FSM encoding, kept as plain constants so older tools can use it.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Defaults match the 4-to-2 one-hot encoder that sits downstream.
    localparam int DEF_NREQ     = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Ceiling log2; returns the bit width needed to index n items.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// Round-robin winner select: first set request at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] rot_oh;
    logic [PW-1:0]   off;
    logic            found;

    // Rotate so ptr lands at bit 0, find the lowest set bit, rotate the hit back.
    always_comb begin
        rot    = '0;
        rot_oh = '0;
        off    = '0;
        found  = 1'b0;
        onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[PW'(i) + ptr];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                found     = 1'b1;
                off       = PW'(i);
                rot_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            onehot[PW'(i) + ptr] = rot_oh[i];
        end
        any = found;
        idx = off + ptr;
    end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter issuing one registered one-hot grant to the 4x2 encoder.
// Latency: 1 cycle from sampled request to grant; 2 dead cycles between grants.
// Backpressure: grant held until done, requester drop, or hold limit under contention.
module onehot_rr_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid
);

    localparam int PW = clog2(NREQ);
    localparam int HW = clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   g;
    logic [HW-1:0]   hold_cnt;

    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic            release_now;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // While granting, grant is exactly one-hot(g), so req & ~grant is "anyone else waiting".
    always_comb begin
        release_now = done
                    || !req[g]
                    || ((hold_cnt == HOLD_LAST) && ((req & ~grant) != '0));
    end

    // Arbitration FSM; ptr moves only on release so a grant never skips its owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= '0;
            g           <= '0;
            hold_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant       <= pick_onehot;
                        grant_valid <= 1'b1;
                        g           <= pick_idx;
                        hold_cnt    <= '0;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        ptr         <= g + 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_GAP;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt    <= hold_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Self-checking bench for onehot_rr_arbiter with a behavioural reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_onehot_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   enc_y;

    int tests = 0;
    int fails = 0;

    // Reference model state: owner index (-1 = nobody), rotation start, cycles held, gap flag.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_gap;

    onehot_rr_arbiter #(
        .NREQ     (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Downstream 4-to-2 one-hot encoder; X on grant propagates to y.
    always_comb begin
        enc_y = grant_valid ? {grant[3] | grant[2], grant[3] | grant[1]} : 2'b00;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_gap   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic d);
        logic [N-1:0] others;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            for (int j = 0; j < N; j++) begin
                if (m_owner < 0 && r[(m_ptr + j) % N]) begin
                    m_owner = (m_ptr + j) % N;
                    m_held  = 1;
                end
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (d || !r[m_owner] || (m_held >= MH && others != 0)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] v;
        v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    // Drive inputs, take one rising edge, advance the model, settle past the edge.
    task automatic tick(input logic [N-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: grant=%b valid=%b, want 0000/0", grant, grant_valid);
        end
        rst_n = 1'b1;
        tick(4'b1111, 1'b0);
        tests++;
        if (grant !== 4'b0001 || grant_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_grant: grant=%b valid=%b, want 0001/1", grant, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_g = '0;
            exp_g[k % N] = 1'b1;
            tick(4'b1111, 1'b0);
            tests++;
            if (grant !== exp_g || grant_valid !== 1'b1) begin
                fails++;
                $display("FAIL rr_grant%0d: grant=%b valid=%b, want %b/1", k, grant, grant_valid, exp_g);
            end
            tick(4'b1111, 1'b1);
            tests++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
                fails++;
                $display("FAIL rr_gap%0d: grant=%b valid=%b, want 0000/0", k, grant, grant_valid);
            end
            tick(4'b1111, 1'b0);
            tests++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
                fails++;
                $display("FAIL rr_idle%0d: grant=%b valid=%b, want 0000/0", k, grant, grant_valid);
            end
        end
    endtask

    task automatic test_pointer_skip();
        do_reset();
        tick(4'b0010, 1'b0);
        tests++;
        if (grant !== 4'b0010) begin
            fails++;
            $display("FAIL skip_first: grant=%b, want 0010", grant);
        end
        tick(4'b0010, 1'b1);
        tick(4'b0011, 1'b0);
        tests++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("FAIL skip_gap_idle: grant=%b, want 0000", grant);
        end
        tick(4'b0011, 1'b0);
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL skip_wrap: grant=%b, want 0001", grant);
        end
    endtask

    task automatic test_hold_limit();
        int held;
        int bad;
        do_reset();
        tick(4'b0101, 1'b0);
        held = (grant === 4'b0001) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick(4'b0101, 1'b0);
            if (grant !== 4'b0001) break;
            held++;
        end
        tests++;
        if (held != MH) begin
            fails++;
            $display("FAIL hold_len: held=%0d cycles, want %0d", held, MH);
        end
        tests++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("FAIL hold_gap: grant=%b, want 0000", grant);
        end
        tick(4'b0101, 1'b0);
        tick(4'b0101, 1'b0);
        tests++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL hold_next: grant=%b, want 0100", grant);
        end
        // A lone requester must keep its grant well past the hold limit.
        do_reset();
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick(4'b0001, 1'b0);
            if (grant !== 4'b0001) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL hold_uncontended: %0d cycles lost the grant, want 0", bad);
        end
    endtask

    task automatic test_simultaneous_release();
        do_reset();
        tick(4'b0100, 1'b0);
        tests++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL simul_first: grant=%b, want 0100", grant);
        end
        tick(4'b0000, 1'b1);
        tick(4'b1111, 1'b0);
        tests++;
        if (grant !== 4'b0000) begin
            fails++;
            $display("FAIL simul_gap: grant=%b, want 0000", grant);
        end
        tick(4'b1111, 1'b0);
        tests++;
        if (grant !== 4'b1000) begin
            fails++;
            $display("FAIL simul_ptr: grant=%b, want 1000", grant);
        end
    endtask

    task automatic test_mid_grant_reset();
        do_reset();
        tick(4'b0100, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: grant=%b valid=%b, want 0000/0", grant, grant_valid);
        end
        #2;
        rst_n = 1'b1;
        tick(4'b1111, 1'b0);
        tests++;
        if (grant !== 4'b0001) begin
            fails++;
            $display("FAIL async_restart: grant=%b, want 0001", grant);
        end
    endtask

    task automatic test_random_e2e();
        logic [N-1:0] r;
        logic [N-1:0] exp_g;
        logic         d;
        do_reset();
        r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) r = N'($urandom_range(0, 15));
            d = ($urandom_range(0, 11) == 0);
            tick(r, d);
            exp_g = model_grant();
            tests++;
            if (grant !== exp_g || grant_valid !== (exp_g != 0)) begin
                fails++;
                $display("FAIL rand_grant@%0d: grant=%b valid=%b, want %b/%b",
                         i, grant, grant_valid, exp_g, (exp_g != 0));
            end
            tests++;
            if (grant_valid !== (|grant) || !$onehot0(grant)) begin
                fails++;
                $display("FAIL rand_invariant@%0d: grant=%b valid=%b", i, grant, grant_valid);
            end
            if (grant_valid === 1'b1) begin
                tests++;
                if ($isunknown(enc_y) || m_owner < 0 || enc_y !== 2'(m_owner)) begin
                    fails++;
                    $display("FAIL e2e_enc@%0d: y=%b, want index %0d", i, enc_y, m_owner);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_pointer_skip();
        test_hold_limit();
        test_simultaneous_release();
        test_mid_grant_reset();
        test_random_e2e();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
